// File: rtl/pixie_pkg.sv
// pixie_pkg: shared bank type, line-buffer entry layout and constants for the scandoubler
package pixie_pkg;
  localparam int NTSC_LINE_LEN = 113;
  localparam int DEFAULT_ADDR_W = 7;
  typedef enum logic {BANK_0 = 1'b0, BANK_1 = 1'b1} bank_t;
  typedef struct packed {
    logic blank;
    logic pix;
  } entry_t;
  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction
endpackage

// File: rtl/pixie_scandoubler_if.sv
// pixie_scandoubler_if: 1861 video input stream and doubled video output bundle
interface pixie_scandoubler_if import pixie_pkg::*; #(parameter int ADDR_W = DEFAULT_ADDR_W);
  logic ce_pix;
  logic vid_in;
  logic hs_in;
  logic vs_in;
  logic hb_in;
  logic vb_in;
  logic vid_out;
  logic hs_out;
  logic vs_out;
  logic hb_out;
  logic vb_out;
  logic de_out;
  logic [ADDR_W:0] line_len;
  modport master (
    output ce_pix, vid_in, hs_in, vs_in, hb_in, vb_in,
    input  vid_out, hs_out, vs_out, hb_out, vb_out, de_out, line_len
  );
  modport slave (
    input  ce_pix, vid_in, hs_in, vs_in, hb_in, vb_in,
    output vid_out, hs_out, vs_out, hb_out, vb_out, de_out, line_len
  );
endinterface

// File: rtl/pixie_line_ram.sv
// pixie_line_ram: two-bank ping-pong line store with sync write and 1-clk registered read
module pixie_line_ram import pixie_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  bank_t             i_wbank,
  input  logic [ADDR_W-1:0] i_waddr,
  input  entry_t            i_wdata,
  input  bank_t             i_rbank,
  input  logic [ADDR_W-1:0] i_raddr,
  output entry_t            o_rdata
);
  entry_t r_mem [2**(ADDR_W+1)];
  entry_t r_rdata;
  // unreset storage and read register so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;
    r_rdata <= r_mem[{i_rbank, i_raddr}];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/pixie_scandoubler.sv
// pixie_scandoubler: captures each 1861 line into a ping-pong buffer and replays it twice at clk rate
module pixie_scandoubler import pixie_pkg::*; #(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int HS_OUT_WIDTH = 6,
  parameter int MIN_LINE     = 16
) (
  input logic                clk,
  input logic                reset,
  pixie_scandoubler_if.slave vif
);
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] L_MIN   = (ADDR_W+1)'(MIN_LINE);
  localparam logic [ADDR_W:0] L_HSW   = (ADDR_W+1)'(HS_OUT_WIDTH);
  logic            r_hs_s;
  logic [ADDR_W:0] r_in_x;
  logic [ADDR_W:0] r_out_x;
  logic [ADDR_W:0] r_len;
  bank_t           r_wbank;
  logic            r_vs_line, r_vs_prev, r_vb_line, r_vb_prev;
  logic            r_vs_out, r_vb_out, r_hs_out, r_force, r_run;
  logic            w_ls, w_we, w_hb;
  bank_t           w_wbank, w_rbank;
  logic [ADDR_W-1:0] w_waddr;
  entry_t          w_wdata, w_rdata;
  assign w_ls    = vif.ce_pix & vif.hs_in & ~r_hs_s;
  assign w_wbank = w_ls ? other_bank(r_wbank) : r_wbank;
  assign w_rbank = other_bank(w_wbank);
  assign w_we    = vif.ce_pix & (w_ls | (r_in_x < L_DEPTH));
  assign w_waddr = w_ls ? '0 : r_in_x[ADDR_W-1:0];
  assign w_wdata = '{blank: vif.hb_in, pix: vif.vid_in};
  pixie_line_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_wbank (w_wbank),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_rbank (w_rbank),
    .i_raddr (r_out_x[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );
  // input side: the line-start pixel is entry 0 of the new bank, so in_x restarts at 1 and saturates at the depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_s    <= 1'b0;
      r_in_x    <= '0;
      r_len     <= '0;
      r_wbank   <= BANK_0;
      r_vs_line <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vb_line <= 1'b0;
      r_vb_prev <= 1'b0;
    end else if (vif.ce_pix) begin
      r_hs_s <= vif.hs_in;
      if (w_ls) begin
        if (r_in_x >= L_MIN) r_len <= r_in_x;
        r_wbank   <= w_wbank;
        r_in_x    <= (ADDR_W+1)'(1);
        r_vs_line <= vif.vs_in;
        r_vs_prev <= r_vs_line;
        r_vb_line <= vif.vb_in;
        r_vb_prev <= r_vb_line;
      end else if (r_in_x < L_DEPTH) begin
        r_in_x <= r_in_x + 1'b1;
      end
    end
  end
  // output side: replay pointer plus sync/blank flags registered alongside the RAM read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run    <= 1'b0;
      r_out_x  <= '0;
      r_hs_out <= 1'b0;
      r_force  <= 1'b0;
      r_vs_out <= 1'b0;
      r_vb_out <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_out_x  <= (w_ls || r_len == '0 || r_out_x >= r_len - 1'b1) ? '0 : r_out_x + 1'b1;
      r_hs_out <= (r_len != '0) && (r_out_x < L_HSW);
      r_force  <= (r_len == '0) || r_out_x[ADDR_W];
      r_vs_out <= r_vs_prev;
      r_vb_out <= r_vb_prev;
    end
  end
  assign w_hb         = r_run & (r_force | w_rdata.blank);
  assign vif.hb_out   = w_hb;
  assign vif.vid_out  = r_run & w_rdata.pix & ~w_hb;
  assign vif.hs_out   = r_hs_out;
  assign vif.vs_out   = r_vs_out;
  assign vif.vb_out   = r_vb_out;
  assign vif.de_out   = r_run & ~(w_hb | r_vb_out);
  assign vif.line_len = r_len;
endmodule

// File: tb/tb_pixie_scandoubler.sv
// tb_pixie_scandoubler: directed line sequences checked against a two-bank line-buffer reference
module tb_pixie_scandoubler;
  import pixie_pkg::*;
  localparam int AW = DEFAULT_ADDR_W;
  localparam int DEPTH = 2**AW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  pixie_scandoubler_if #(.ADDR_W(AW)) vif ();
  pixie_scandoubler #(.ADDR_W(AW), .HS_OUT_WIDTH(6), .MIN_LINE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [1:0] m_bank [2][DEPTH];
  bit         m_val  [2][DEPTH];
  int m_wb, m_len, m_prev_cnt;
  bit m_vs_line, m_vs_prev, m_vb_line, m_vb_prev;
  task automatic expect_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic logic [1:0] pix(input int pat, input int k);
    bit act;
    act = (k >= 16) && (k < 80);
    if (pat == 0) return {~act, act};
    if (pat == 1) return {~act, act && (k % 2 == 0)};
    return {k < 8, (k >= 8) && (k % 3 == 0)};
  endfunction
  task automatic model_reset();
    m_wb = 0; m_len = 0; m_prev_cnt = 0;
    m_vs_line = 0; m_vs_prev = 0; m_vb_line = 0; m_vb_prev = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_val[b][a] = 0;
  endtask
  task automatic check_idle(input string tag, input int hb);
    expect_eq({tag, "_vid"}, vif.vid_out, 0);
    expect_eq({tag, "_hs"}, vif.hs_out, 0);
    expect_eq({tag, "_vs"}, vif.vs_out, 0);
    expect_eq({tag, "_hb"}, vif.hb_out, hb);
    expect_eq({tag, "_vb"}, vif.vb_out, 0);
    expect_eq({tag, "_de"}, vif.de_out, 0);
    expect_eq({tag, "_len"}, vif.line_len, 0);
  endtask
  task automatic check_pos(input int j, input int rb);
    int r, ehs, ehb, evid;
    bit ok;
    logic [1:0] e;
    if (m_len == 0) begin
      ehs = 0; ehb = 1; evid = 0; ok = 1;
    end else begin
      r = j % m_len;
      ehs = (r < 6) ? 1 : 0;
      ok = m_val[rb][r];
      e = m_bank[rb][r];
      ehb = e[1];
      evid = e[0] & ~e[1];
    end
    expect_eq($sformatf("hs_out[%0d]", j), vif.hs_out, ehs);
    expect_eq($sformatf("vs_out[%0d]", j), vif.vs_out, m_vs_prev);
    expect_eq($sformatf("vb_out[%0d]", j), vif.vb_out, m_vb_prev);
    if (ok) begin
      expect_eq($sformatf("hb_out[%0d]", j), vif.hb_out, ehb);
      expect_eq($sformatf("vid_out[%0d]", j), vif.vid_out, evid);
      expect_eq($sformatf("de_out[%0d]", j), vif.de_out, (ehb | m_vb_prev) ? 0 : 1);
    end
  endtask
  task automatic send_line(input int n, input int pat, input bit vs, input bit vb, input bit chk);
    int k, rb;
    if (m_prev_cnt >= 16) m_len = m_prev_cnt;
    m_wb = 1 - m_wb;
    m_vs_prev = m_vs_line; m_vs_line = vs;
    m_vb_prev = m_vb_line; m_vb_line = vb;
    rb = 1 - m_wb;
    for (int c = 0; c < 2 * n; c++) begin
      k = c / 2;
      vif.ce_pix = (c % 2 == 0);
      {vif.hb_in, vif.vid_in} = pix(pat, k);
      vif.hs_in = (k < 2);
      vif.vs_in = vs;
      vif.vb_in = vb;
      @(posedge clk);
      #1;
      if (chk && c >= 1) check_pos(c - 1, rb);
      if (chk && c == 1) expect_eq("line_len", vif.line_len, m_len);
    end
    for (int a = 0; a < n && a < DEPTH; a++) begin
      m_bank[m_wb][a] = pix(pat, a);
      m_val[m_wb][a] = 1;
    end
    m_prev_cnt = (n > DEPTH) ? DEPTH : n;
  endtask
  initial begin
    {vif.ce_pix, vif.vid_in, vif.hs_in, vif.vs_in, vif.hb_in, vif.vb_in} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("por", 0);
    reset = 1'b1;
    send_line(NTSC_LINE_LEN, 0, 0, 0, 0);
    send_line(30, 0, 0, 0, 0);
    #3 reset = 1'b0;
    #1;
    check_idle("async_rst", 0);
    vif.ce_pix = 1'b0;
    @(posedge clk);
    #1;
    check_idle("rst_held", 0);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_idle("rst_release", 1);
    for (int n = 0; n < 10; n++) send_line(NTSC_LINE_LEN, 0, n < 8, n < 4, 1);
    send_line(200, 2, 0, 0, 1);
    send_line(NTSC_LINE_LEN, 1, 0, 0, 1);
    send_line(NTSC_LINE_LEN, 0, 0, 0, 1);
    send_line(5, 0, 0, 0, 1);
    send_line(NTSC_LINE_LEN, 0, 0, 0, 1);
    send_line(NTSC_LINE_LEN, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
